// File: rtl/uart_sipo_rx.sv
// rtl/uart_sipo_rx.sv - UART serial-in parallel-out receiver, one baud_clk edge per bit
// Frame: start 0, DATA_BITS data LSB first, one parity bit, stop 1.
module uart_sipo_rx #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 baud_clk,
  input  logic                 rst,
  input  logic                 data_rx,
  input  logic                 data_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 done_flag,
  output logic                 active_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t               state;
  state_t               state_n;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [DATA_BITS-1:0] shift_q;
  logic [CW-1:0]        cnt_q;
  logic                 rx_parity;

  logic                 cnt_clr;
  logic                 shift_en;
  logic                 cap_par;
  logic                 finish;

  // The line is asynchronous; only the second flop output feeds the FSM.
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], data_rx};
    end
  end

  assign rx_s = sync_q[1];

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_clr  = 1'b0;
    shift_en = 1'b0;
    cap_par  = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_n = ST_DATA;
          cnt_clr = 1'b1;
        end
      end
      ST_DATA: begin
        shift_en = 1'b1;
        if (cnt_q == LAST_BIT) begin
          state_n = ST_PARITY;
        end
      end
      ST_PARITY: begin
        cap_par = 1'b1;
        state_n = ST_STOP;
      end
      ST_STOP: begin
        finish  = 1'b1;
        state_n = rx_s ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: begin
        // A low stop bit means the line may be held in break; wait for idle.
        if (rx_s) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign active_flag = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      rx_parity  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      done_flag  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      done_flag <= finish;
      if (cnt_clr) begin
        cnt_q <= '0;
      end
      if (shift_en) begin
        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
        cnt_q   <= cnt_q + 1'b1;
      end
      if (cap_par) begin
        rx_parity <= rx_s;
      end
      if (finish) begin
        data_out   <= shift_q;
        frame_err  <= ~rx_s;
        parity_err <= (^shift_q) ^ rx_parity ^ PARITY_ODD;
        data_valid <= 1'b1;
        // An ack landing with the new frame consumes the old word: no overrun.
        if (data_valid && !data_ack) begin
          overrun <= 1'b1;
        end
      end else if (data_ack) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_sipo_rx.sv
// tb/tb_uart_sipo_rx.sv - self-checking bench for uart_sipo_rx (even and odd parity instances)
module tb_uart_sipo_rx;

  logic       baud_clk = 1'b0;
  logic       rst      = 1'b1;
  logic       data_rx  = 1'b1;
  logic       data_ack = 1'b0;

  logic [7:0] e_data_out, o_data_out;
  logic       e_valid, o_valid, e_done, o_done, e_active, o_active;
  logic       e_perr, o_perr, e_ferr, o_ferr, e_ovr, o_ovr;

  int cyc       = 0;
  int check_cnt = 0;
  int pass_cnt  = 0;

  int         exp_cyc[$];
  logic [7:0] exp_data[$];
  logic       exp_pe_even[$];
  logic       exp_pe_odd[$];
  logic       exp_fe[$];

  int         obs_cyc[$];
  logic [7:0] obs_data[$];
  logic       obs_pe_even[$];
  logic       obs_pe_odd[$];
  logic       obs_fe[$];

  uart_sipo_rx #(.DATA_BITS(8), .PARITY_ODD(1'b0)) u_even (
    .baud_clk    (baud_clk),
    .rst         (rst),
    .data_rx     (data_rx),
    .data_ack    (data_ack),
    .data_out    (e_data_out),
    .data_valid  (e_valid),
    .done_flag   (e_done),
    .active_flag (e_active),
    .parity_err  (e_perr),
    .frame_err   (e_ferr),
    .overrun     (e_ovr)
  );

  uart_sipo_rx #(.DATA_BITS(8), .PARITY_ODD(1'b1)) u_odd (
    .baud_clk    (baud_clk),
    .rst         (rst),
    .data_rx     (data_rx),
    .data_ack    (data_ack),
    .data_out    (o_data_out),
    .data_valid  (o_valid),
    .done_flag   (o_done),
    .active_flag (o_active),
    .parity_err  (o_perr),
    .frame_err   (o_ferr),
    .overrun     (o_ovr)
  );

  always #5 baud_clk = ~baud_clk;

  always @(posedge baud_clk) cyc <= cyc + 1;

  // Every done pulse cycle is logged with the outputs it published.
  always @(negedge baud_clk) begin
    if (e_done) begin
      obs_cyc.push_back(cyc);
      obs_data.push_back(e_data_out);
      obs_pe_even.push_back(e_perr);
      obs_pe_odd.push_back(o_perr);
      obs_fe.push_back(e_ferr);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge baud_clk);
    #1;
  endtask

  task automatic idle(input int n);
    data_rx = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drives one frame and records what a correct receiver must report for it.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    int ones;
    ones = $countones(d) + int'(p);
    exp_cyc.push_back(cyc + 13);
    exp_data.push_back(d);
    exp_pe_even.push_back((ones % 2) != 0);
    exp_pe_odd.push_back((ones % 2) == 0);
    exp_fe.push_back(!s);
    data_rx = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      data_rx = d[i];
      tick();
    end
    data_rx = p;
    tick();
    data_rx = s;
    tick();
  endtask

  task automatic ack_pulse();
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, obs_cyc.size(), exp_cyc.size());
    while (obs_cyc.size() > 0 && exp_cyc.size() > 0) begin
      chk({tag, "_done_cyc"}, obs_cyc.pop_front(), exp_cyc.pop_front());
      chk({tag, "_data"}, obs_data.pop_front(), exp_data.pop_front());
      chk({tag, "_perr_even"}, obs_pe_even.pop_front(), exp_pe_even.pop_front());
      chk({tag, "_perr_odd"}, obs_pe_odd.pop_front(), exp_pe_odd.pop_front());
      chk({tag, "_ferr"}, obs_fe.pop_front(), exp_fe.pop_front());
    end
    obs_cyc.delete(); obs_data.delete(); obs_pe_even.delete(); obs_pe_odd.delete(); obs_fe.delete();
    exp_cyc.delete(); exp_data.delete(); exp_pe_even.delete(); exp_pe_odd.delete(); exp_fe.delete();
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    logic       s;
    logic [7:0] rf = 8'h99;

    // Reset state
    rst = 1'b1;
    idle(3);
    chk("rst_data_out", e_data_out, 8'h00);
    chk("rst_valid", e_valid, 1'b0);
    chk("rst_done", e_done, 1'b0);
    chk("rst_active", e_active, 1'b0);
    chk("rst_perr", e_perr, 1'b0);
    chk("rst_ferr", e_ferr, 1'b0);
    chk("rst_overrun", e_ovr, 1'b0);
    chk("rst_odd_perr", o_perr, 1'b0);
    rst = 1'b0;
    idle(3);

    // 0xCC, good parity and stop; odd instance sees a parity error
    send_frame(8'hCC, 1'b0, 1'b1);
    chk("cc_active_at_stop", e_active, 1'b1);
    idle(3);
    check_events("cc");
    chk("cc_valid", e_valid, 1'b1);
    chk("cc_active_idle", e_active, 1'b0);
    ack_pulse();
    chk("cc_ack_valid", e_valid, 1'b0);
    ack_pulse();
    chk("ack_when_empty", e_valid, 1'b0);

    // 0xAA with parity 1
    send_frame(8'hAA, 1'b1, 1'b1);
    idle(3);
    check_events("aa");
    chk("aa_even_perr", e_perr, 1'b1);
    chk("aa_odd_perr", o_perr, 1'b0);
    ack_pulse();

    // Bad stop bit, line held low, then a clean frame
    send_frame(8'h55, 1'b0, 1'b0);
    data_rx = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("brk_active", e_active, 1'b0);
    chk("brk_ferr", e_ferr, 1'b1);
    idle(3);
    check_events("brk55");
    ack_pulse();
    send_frame(8'h0F, 1'b0, 1'b1);
    idle(3);
    check_events("after_brk");
    chk("0f_ferr_cleared", e_ferr, 1'b0);
    ack_pulse();

    // Back-to-back without ack
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    idle(3);
    check_events("b2b");
    chk("b2b_data", e_data_out, 8'h34);
    chk("b2b_valid", e_valid, 1'b1);
    chk("b2b_overrun", e_ovr, 1'b1);
    ack_pulse();
    chk("b2b_ack_valid", e_valid, 1'b0);
    chk("b2b_overrun_sticky", e_ovr, 1'b1);

    // Reset during data bit 4
    data_rx = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      data_rx = rf[i];
      tick();
    end
    data_rx = rf[4];
    rst = 1'b1;
    data_ack = 1'b1;
    tick();
    rst = 1'b0;
    data_ack = 1'b0;
    data_rx = 1'b1;
    chk("midrst_data_out", e_data_out, 8'h00);
    chk("midrst_valid", e_valid, 1'b0);
    chk("midrst_active", e_active, 1'b0);
    chk("midrst_overrun", e_ovr, 1'b0);
    chk("midrst_perr", e_perr, 1'b0);
    chk("midrst_ferr", e_ferr, 1'b0);
    idle(15);
    check_events("midrst_no_done");
    send_frame(8'h81, 1'b0, 1'b1);
    idle(3);
    check_events("post_rst");
    chk("81_valid", e_valid, 1'b1);
    chk("81_overrun", e_ovr, 1'b0);

    // Ack coincides with completion of the next frame
    send_frame(8'h5A, 1'b0, 1'b1);
    tick();
    data_ack = 1'b1;
    tick();
    data_ack = 1'b0;
    chk("ackcomp_done", e_done, 1'b1);
    chk("ackcomp_valid", e_valid, 1'b1);
    chk("ackcomp_data", e_data_out, 8'h5A);
    chk("ackcomp_overrun", e_ovr, 1'b0);
    idle(2);
    check_events("ackcomp");
    ack_pulse();

    // Randomized frames against the reference model
    for (int n = 0; n < 24; n++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s);
      idle(3 + $urandom_range(0, 2));
      chk("rnd_data", e_data_out, d);
      chk("rnd_odd_data", o_data_out, d);
      chk("rnd_ferr", e_ferr, !s);
      chk("rnd_valid", e_valid, 1'b1);
      ack_pulse();
      chk("rnd_ack_valid", e_valid, 1'b0);
    end
    check_events("rnd");
    chk("rnd_overrun", e_ovr, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
